// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 3x4 phone keypad: key code constants, scanner FSM
// state encoding, round result encoding and the (row, col) -> code mapping.
// Imported by keypad_scanner and by GameManager so both agree on code values.
// Layout: row0 = 1 2 3, row1 = 4 5 6, row2 = 7 8 9, row3 = * 0 #.
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } round_res_e;

  // Digits 1..9 follow row*3 + col + 1; the bottom row is remapped to * 0 #.
  function automatic logic [3:0] key_code_of(input logic [1:0] row,
                                             input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a bus of independent asynchronous level signals.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears both stages
//   d_i    - asynchronous input bus
//   q_o    - synchronised output bus (two clk_i cycles of latency)
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 3x4 phone keypad column by column, classifies each full scan round
// as NONE / KEY(code) / MULTI, debounces presses and releases over
// DEBOUNCE_ROUNDS identical rounds and emits one key event per press.
// Ports:
//   clk_2       - system clock
//   rst_n       - asynchronous active-low reset
//   KEY_ROW     - raw row lines, active-high, asynchronous
//   KEY_COL     - one-hot column drive, active-high
//   key_valid   - one-cycle pulse when a debounced press is accepted
//   key_code    - code of the last accepted key (KEY_NONE after reset)
//   key_held    - high from acceptance until the release is debounced
//   key_multi   - high while the last completed round saw two or more keys
//   dbg_state_o - current debounce FSM state
// Handshake: key_valid is a single-cycle strobe with no back-pressure; the
// consumer must capture key_code in the cycle key_valid is high (key_code also
// stays stable until the next accepted press).
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_ROUNDS = 4
) (
  input  logic       clk_2,
  input  logic       rst_n,
  input  logic [3:0] KEY_ROW,
  output logic [2:0] KEY_COL,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       key_multi,
  output kp_state_e  dbg_state_o
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_ROUNDS + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  // The FSM leaves the debounce state on the round that would bring the
  // count to DEBOUNCE_ROUNDS, so deb_cnt never exceeds DEBOUNCE_ROUNDS-1.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_ROUNDS - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [3:0] row_sync;

  sync2 #(.W(4)) u_row_sync (
    .clk_i  (clk_2),
    .rst_ni (rst_n),
    .d_i    (KEY_ROW),
    .q_o    (row_sync)
  );

  // ---------------------------------------------------------------------------
  // Scan counter and column rotation
  // ---------------------------------------------------------------------------
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    col_q, col_d;
  logic          slot_end;
  logic          round_end;

  // Sampling on the last slot cycle leaves >= 3 cycles for the column drive
  // to propagate through the keypad and the synchroniser.
  assign slot_end  = (slot_cnt_q == SCAN_LAST);
  assign round_end = slot_end & col_q[2];

  always_comb begin
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + SW'(1);
    col_d      = slot_end ? {col_q[1:0], col_q[2]} : col_q;
  end

  // ---------------------------------------------------------------------------
  // Round evaluator: accumulates a saturating key count (0, 1, 2+) and the
  // code of the first key seen across the three column samples.
  // ---------------------------------------------------------------------------
  logic [1:0] acc_cnt_q, acc_cnt_d;
  logic [3:0] acc_code_q, acc_code_d;
  logic [2:0] row_pop;
  logic [2:0] tot_cnt;
  logic [1:0] cur_cnt;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [3:0] cur_code;
  round_res_e round_res;

  always_comb begin
    row_pop = 3'(row_sync[0]) + 3'(row_sync[1]) + 3'(row_sync[2]) + 3'(row_sync[3]);
    tot_cnt = {1'b0, acc_cnt_q} + row_pop;
    cur_cnt = (tot_cnt >= 3'd2) ? 2'd2 : tot_cnt[1:0];

    if (row_sync[3])      row_idx = 2'd3;
    else if (row_sync[2]) row_idx = 2'd2;
    else if (row_sync[1]) row_idx = 2'd1;
    else                  row_idx = 2'd0;

    if (col_q[2])      col_idx = 2'd2;
    else if (col_q[1]) col_idx = 2'd1;
    else               col_idx = 2'd0;

    // The stored code is only meaningful when exactly one key was counted.
    cur_code = (acc_cnt_q == 2'd0) ? key_code_of(row_idx, col_idx) : acc_code_q;

    case (cur_cnt)
      2'd0:    round_res = RES_NONE;
      2'd1:    round_res = RES_KEY;
      default: round_res = RES_MULTI;
    endcase

    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (round_end) begin
      acc_cnt_d  = 2'd0;
      acc_code_d = KEY_NONE;
    end else if (slot_end) begin
      acc_cnt_d  = cur_cnt;
      acc_code_d = cur_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  kp_state_e     state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          multi_q, multi_d;
  logic          accept;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      col_q      <= 3'b001;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= KEY_NONE;
      state_q    <= ST_IDLE;
      deb_cnt_q  <= '0;
      cand_q     <= KEY_NONE;
      code_q     <= KEY_NONE;
      valid_q    <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      col_q      <= col_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      multi_q    <= multi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next-state logic (only advances on round boundaries)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    cand_d    = cand_q;
    accept    = 1'b0;

    if (round_end) begin
      case (state_q)
        ST_IDLE: begin
          if (round_res == RES_KEY) begin
            cand_d = cur_code;
            if (DEBOUNCE_ROUNDS == 1) begin
              state_d   = ST_HELD;
              accept    = 1'b1;
              deb_cnt_d = '0;
            end else begin
              state_d   = ST_PRESS_DB;
              deb_cnt_d = DW'(1);
            end
          end
        end
        ST_PRESS_DB: begin
          if (round_res == RES_KEY && cur_code == cand_q) begin
            if (deb_cnt_q == DEB_LAST) begin
              state_d   = ST_HELD;
              accept    = 1'b1;
              deb_cnt_d = '0;
            end else begin
              deb_cnt_d = deb_cnt_q + DW'(1);
            end
          end else if (round_res == RES_KEY) begin
            cand_d    = cur_code;
            deb_cnt_d = DW'(1);
          end else begin
            state_d   = ST_IDLE;
            deb_cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (round_res == RES_NONE) begin
            if (DEBOUNCE_ROUNDS == 1) begin
              state_d   = ST_IDLE;
              deb_cnt_d = '0;
            end else begin
              state_d   = ST_RELEASE_DB;
              deb_cnt_d = DW'(1);
            end
          end
        end
        ST_RELEASE_DB: begin
          if (round_res == RES_NONE) begin
            if (deb_cnt_q == DEB_LAST) begin
              state_d   = ST_IDLE;
              deb_cnt_d = '0;
            end else begin
              deb_cnt_d = deb_cnt_q + DW'(1);
            end
          end else begin
            state_d   = ST_HELD;
            deb_cnt_d = '0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          deb_cnt_d = '0;
        end
      endcase
    end

    code_d  = accept ? cand_d : code_q;
    valid_d = accept;
    multi_d = round_end ? (round_res == RES_MULTI) : multi_q;
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    KEY_COL     = col_q;
    key_valid   = valid_q;
    key_code    = code_q;
    key_held    = (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);
    key_multi   = multi_q;
    dbg_state_o = state_q;
  end

endmodule
